// File: rtl/level_loader_pkg.sv
// Shared defaults, encodings and FSM state type for the brick-field level loader.
package level_loader_pkg;

  localparam int unsigned DefaultBrickNum  = 40;
  localparam int unsigned DefaultColsLog2  = 3;
  localparam int unsigned DefaultBrickW    = 20;
  localparam int unsigned DefaultBrickH    = 10;
  localparam int unsigned DefaultXOrg      = 0;
  localparam int unsigned DefaultYOrg      = 0;
  localparam int unsigned DefaultDrawDelay = 16;
  localparam int unsigned DefaultNumLevels = 4;
  localparam int unsigned DefaultLvlW      = 2;

  localparam int unsigned IdxW   = 10;
  localparam int unsigned CoordW = 12;

  // Fixed layout of the level table contents: 40 bricks, 8 per row.
  localparam int unsigned RomBricks   = 40;
  localparam int unsigned RomColsLog2 = 3;

  typedef enum logic [1:0] {
    HealthEmpty  = 2'd0,
    HealthWeak   = 2'd1,
    HealthMid    = 2'd2,
    HealthStrong = 2'd3
  } health_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDraw,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/level_rom.sv
// Initial brick health per level; indices outside the table and unknown levels read empty.
module level_rom
  import level_loader_pkg::*;
#(
  parameter int unsigned LVL_W = DefaultLvlW
) (
  input  logic [LVL_W-1:0] lvl,
  input  logic [IdxW-1:0]  idx,
  output logic [1:0]       health
);

  int unsigned lvl_n;
  int unsigned row;
  int unsigned row_mod3;

  always_comb begin
    health   = HealthEmpty;
    lvl_n    = 32'(lvl);
    row      = 32'(idx >> RomColsLog2);
    row_mod3 = row % 3;
    if (32'(idx) < RomBricks) begin
      case (lvl_n)
        0: health = 2'(row_mod3 + 1);
        // Bricks 5..7 left empty to exercise the skip path.
        1: health = (idx >= 10'd5 && idx <= 10'd7) ? HealthEmpty : HealthMid;
        2: health = 2'(3 - row_mod3);
        3: health = idx[0] ? HealthEmpty : HealthWeak;
        default: health = HealthEmpty;
      endcase
    end
  end

endmodule

// File: rtl/level_loader.sv
// Walks every brick of the selected level, strobing a draw request, dwelling, then writing
// the brick's address, pixel position and initial health to brick memory.
module level_loader
  import level_loader_pkg::*;
#(
  parameter int unsigned BRICK_NUM  = DefaultBrickNum,
  parameter int unsigned COLS_LOG2  = DefaultColsLog2,
  parameter int unsigned BRICK_W    = DefaultBrickW,
  parameter int unsigned BRICK_H    = DefaultBrickH,
  parameter int unsigned X_ORG      = DefaultXOrg,
  parameter int unsigned Y_ORG      = DefaultYOrg,
  parameter int unsigned DRAW_DELAY = DefaultDrawDelay,
  parameter int unsigned NUM_LEVELS = DefaultNumLevels,
  parameter int unsigned LVL_W      = DefaultLvlW,
  parameter bit          SKIP_EMPTY = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic             we,
  output logic [9:0]       address,
  output logic [9:0]       x_out,
  output logic [9:0]       y_out,
  output logic [1:0]       health
);

  localparam int unsigned DlyW = $clog2(DRAW_DELAY + 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d, lvl_sel;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic                skip;
  logic [CoordW-1:0]   x_full, y_full;

  level_rom #(
    .LVL_W(LVL_W)
  ) u_level_rom (
    .lvl   (lvl_q),
    .idx   (idx_q),
    .health(health)
  );

  assign skip    = SKIP_EMPTY && (health == HealthEmpty);
  // Out-of-range level selects fall back to level 0.
  assign lvl_sel = (32'(level) < NUM_LEVELS) ? level : '0;

  always_comb begin
    x_full = CoordW'(X_ORG + 32'(idx_q[COLS_LOG2-1:0]) * BRICK_W);
    y_full = CoordW'(Y_ORG + 32'(idx_q >> COLS_LOG2) * BRICK_H);
  end

  assign address = idx_q;
  assign x_out   = x_full[9:0];
  assign y_out   = y_full[9:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lvl_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    dly_d   = dly_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (start) begin
          state_d = StPrep;
          idx_d   = '0;
          lvl_d   = lvl_sel;
          dly_d   = '0;
        end
      end
      StPrep: begin
        busy    = 1'b1;
        dly_d   = '0;
        load    = !skip;
        state_d = skip ? StLoad : StDraw;
      end
      StDraw: begin
        busy  = 1'b1;
        dly_d = dly_q + 1'b1;
        if (dly_q == DlyW'(DRAW_DELAY - 1)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        busy = 1'b1;
        // Empty bricks are written too so stale RAM contents clear.
        we   = 1'b1;
        if (idx_q == IdxW'(BRICK_NUM - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StPrep;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_level_loader.sv
// Directed bench for level_loader: full walks, geometry, skip timing, start handshake, reset.
module tb_level_loader;

  logic       clk = 1'b0;
  logic       resetn, start, start_s;
  logic [1:0] level;

  logic       busy, done, load, we;
  logic [9:0] address, x_out, y_out;
  logic [1:0] health;
  logic       busy_s, done_s, load_s, we_s;
  logic [9:0] address_s, x_out_s, y_out_s;
  logic [1:0] health_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int         we_addr[$];
  int         load_cnt;
  logic [63:0] loaded;
  logic [9:0] wx[64];
  logic [9:0] wy[64];
  logic [1:0] wh[64];
  int         wt[64];

  always #5 clk = ~clk;

  level_loader dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .level  (level),
    .busy   (busy),
    .done   (done),
    .load   (load),
    .we     (we),
    .address(address),
    .x_out  (x_out),
    .y_out  (y_out),
    .health (health)
  );

  level_loader #(
    .BRICK_NUM (1),
    .DRAW_DELAY(1)
  ) dut_s (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_s),
    .level  (level),
    .busy   (busy_s),
    .done   (done_s),
    .load   (load_s),
    .we     (we_s),
    .address(address_s),
    .x_out  (x_out_s),
    .y_out  (y_out_s),
    .health (health_s)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      we_addr.push_back(int'(address));
      wx[address[5:0]] = x_out;
      wy[address[5:0]] = y_out;
      wh[address[5:0]] = health;
      wt[address[5:0]] = cyc;
    end
    if (load) begin
      load_cnt++;
      loaded[address[5:0]] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    we_addr.delete();
    load_cnt = 0;
    loaded   = '0;
  endtask

  // Counts edges after the accepting edge until done is seen, bounded.
  task automatic wait_done(input int n_in, output int n_out);
    n_out = n_in;
    while (!done && n_out < 3000) begin
      tick();
      n_out++;
    end
  endtask

  task automatic walk(input logic [1:0] lv, output int n);
    clear_log();
    level = lv;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, n);
  endtask

  int n;
  int bad;

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    level   = 2'd0;
    clear_log();
    repeat (3) tick();

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load_we", 32'({load, we}), 0);
    check("rst_addr", 32'(address), 0);
    check("rst_xy", 32'({x_out, y_out}), 0);
    check("rst_health", 32'(health), 1);
    resetn = 1'b1;
    tick();

    // Level 0, all bricks drawn.
    clear_log();
    level = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("l0_first_load", 32'(load), 1);
    check("l0_first_busy", 32'(busy), 1);
    check("l0_first_we", 32'(we), 0);
    wait_done(0, n);
    check("l0_done_cycles", 32'(n), 720);
    check("l0_we_count", 32'(we_addr.size()), 40);
    check("l0_load_count", 32'(load_cnt), 40);
    bad = 0;
    foreach (we_addr[i]) if (we_addr[i] != i) bad++;
    check("l0_addr_order", 32'(bad), 0);
    check("x_idx11", 32'(wx[11]), 60);
    check("y_idx11", 32'(wy[11]), 10);
    check("x_idx39", 32'(wx[39]), 140);
    check("y_idx39", 32'(wy[39]), 40);
    check("l0_health13", 32'(wh[13]), 2);
    check("done_busy", 32'(busy), 0);
    check("done_addr_held", 32'(address), 39);

    // Level 1: bricks 5..7 empty and skipped; restart straight from DONE.
    walk(2'd1, n);
    check("l1_done_cycles", 32'(n), 37 * 18 + 3 * 2);
    check("l1_we_count", 32'(we_addr.size()), 40);
    check("l1_load_count", 32'(load_cnt), 37);
    check("l1_no_load_5_7", 32'(loaded[7:5]), 0);
    check("l1_load_4_8", 32'({loaded[8], loaded[4]}), 3);
    check("l1_skip_time", 32'(wt[5] - wt[4]), 2);
    check("l1_skip_time7", 32'(wt[7] - wt[6]), 2);
    check("l1_draw_time", 32'(wt[8] - wt[7]), 18);
    check("l1_health5", 32'(wh[5]), 0);

    // start held through the walk while level changes: no restart, level stays 0.
    clear_log();
    level = 2'd0;
    start = 1'b1;
    tick();
    repeat (5) tick();
    level = 2'd2;
    repeat (95) tick();
    check("held_addr", 32'(address), 5);
    check("held_health", 32'(health), 1);
    start = 1'b0;
    wait_done(100, n);
    check("held_done_cycles", 32'(n), 720);
    check("held_we_count", 32'(we_addr.size()), 40);
    check("held_health16", 32'(wh[16]), 3);

    // Level 2 full walk after done.
    walk(2'd2, n);
    check("l2_done_cycles", 32'(n), 720);
    check("l2_we_count", 32'(we_addr.size()), 40);
    check("l2_health0", 32'(wh[0]), 3);
    check("l2_health16", 32'(wh[16]), 1);

    // Reset during the DRAW dwell of brick 3.
    clear_log();
    level = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    check("mid_addr", 32'(address), 3);
    check("mid_busy", 32'(busy), 1);
    resetn = 1'b0;
    tick();
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_we", 32'(we), 0);
    check("rst_mid_addr", 32'(address), 0);
    repeat (20) tick();
    check("rst_mid_we_count", 32'(we_addr.size()), 3);
    resetn = 1'b1;
    tick();
    walk(2'd0, n);
    check("post_rst_cycles", 32'(n), 720);
    check("post_rst_first", 32'(we_addr.size() > 0 ? we_addr[0] : -1), 0);

    // DRAW_DELAY=1, BRICK_NUM=1 instance.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check("s_prep_load", 32'({load_s, we_s}), 2);
    tick();
    check("s_draw", 32'({load_s, we_s, done_s}), 0);
    tick();
    check("s_load_we", 32'({we_s, done_s}), 2);
    tick();
    check("s_done", 32'({done_s, busy_s}), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
